// File: rtl/colour_tracker_pkg.sv
// -----------------------------------------------------------------------------
// colour_tracker_pkg
// Shared types and compile-time helpers for the colour centroid tracker:
//   - tracker_state_t : result-computation FSM states
//   - x_width / cnt_width / zone_width : derived vector widths
//   - zone_boundary   : first column that belongs to steering zone k
// -----------------------------------------------------------------------------
package colour_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_ZONE,
    ST_PUBLISH
  } tracker_state_t;

  // Width of a column index 0..h_active-1.
  function automatic int x_width(input int h_active);
    return $clog2(h_active);
  endfunction

  // Width of a per-frame hit count 0..h_active*v_active.
  function automatic int cnt_width(input int h_active, input int v_active);
    return $clog2(h_active * v_active + 1);
  endfunction

  // Width of a zone index 0..num_zones-1.
  function automatic int zone_width(input int num_zones);
    return $clog2(num_zones);
  endfunction

  // Smallest column c with floor(c*num_zones/h_active) >= k, i.e.
  // ceil(k*h_active/num_zones). Comparing the centroid against these
  // constants replaces a run-time multiply and divide.
  function automatic int zone_boundary(input int k, input int h_active,
                                       input int num_zones);
    return (k * h_active + num_zones - 1) / num_zones;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per clock, SUM_W clocks per
// division. A zero divisor yields a zero quotient and still takes SUM_W clocks.
//   clk, reset : clock, synchronous active-high reset
//   start      : load dividend/divisor and begin (restarts a busy divider)
//   dividend   : SUM_W-bit numerator
//   divisor    : SUM_W-bit denominator
//   busy       : division in progress
//   done       : high in the cycle whose clock edge writes the last quotient
//                bit; quotient is final from the following cycle
//   quotient   : SUM_W-bit result, held until the next start
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int SUM_W = 29
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int CW = $clog2(SUM_W + 1);

  logic [SUM_W-1:0] rem;
  logic [SUM_W-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [SUM_W:0]   trial;
  logic [SUM_W-1:0] diff;
  logic             ge;

  // The quotient register doubles as the dividend shift register: its MSB is
  // shifted into the partial remainder while the new quotient bit enters at
  // the LSB.
  always_comb begin
    trial = {rem, quotient[SUM_W-1]};
    // trial < 2*dvs whenever ge is set, so the low SUM_W bits are exact.
    diff  = trial[SUM_W-1:0] - dvs;
    ge    = (dvs != '0) && (trial >= {1'b0, dvs});
  end

  assign done = busy && (cnt == CW'(1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= CW'(SUM_W);
      rem      <= '0;
      dvs      <= divisor;
      quotient <= dividend;
    end else if (busy) begin
      rem      <= ge ? diff : trial[SUM_W-1:0];
      quotient <= {quotient[SUM_W-2:0], ge};
      cnt      <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/colour_centroid_tracker.sv
// -----------------------------------------------------------------------------
// colour_centroid_tracker
// Per-frame centroid tracker for NUM_CH colour-classifier flags. Accumulates
// hit count and column sum per channel over the active area; at each frame
// boundary it divides (shared sequential divider) to get the mean column,
// quantises it into NUM_ZONES steering zones and publishes the results.
//   clk, reset   : pixel clock, synchronous active-high reset
//   frame_start  : one-cycle pulse before the first active pixel of a frame
//   pixel_valid  : active-area pixel strobe
//   hit          : per-channel classifier flags, qualified by pixel_valid
//   result_valid : one-cycle pulse when the result outputs have been updated
//   detected     : per-channel count >= MIN_PIXELS for the last frame
//   centroid_x   : per-channel mean column, channel k at [k*X_W +: X_W]
//   zone         : per-channel steering zone, channel k at [k*Z_W +: Z_W]
//   overrun      : one-cycle pulse when frame_start cut a computation short
// -----------------------------------------------------------------------------
module colour_centroid_tracker
  import colour_tracker_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int NUM_ZONES  = 5,
  parameter int MIN_PIXELS = 64
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      frame_start,
  input  logic                                      pixel_valid,
  input  logic [NUM_CH-1:0]                         hit,
  output logic                                      result_valid,
  output logic [NUM_CH-1:0]                         detected,
  output logic [NUM_CH*x_width(H_ACTIVE)-1:0]       centroid_x,
  output logic [NUM_CH*zone_width(NUM_ZONES)-1:0]   zone,
  output logic                                      overrun
);

  localparam int X_W   = x_width(H_ACTIVE);
  localparam int CNT_W = cnt_width(H_ACTIVE, V_ACTIVE);
  localparam int SUM_W = X_W + CNT_W;
  localparam int Z_W   = zone_width(NUM_ZONES);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // ---------------------------------------------------------------------------
  // Column counter and per-channel accumulators
  // ---------------------------------------------------------------------------
  logic [X_W-1:0]   x;
  logic [X_W-1:0]   x_cur;
  logic [CNT_W-1:0] acc_cnt [NUM_CH];
  logic [SUM_W-1:0] acc_sum [NUM_CH];
  logic [CNT_W-1:0] shd_cnt [NUM_CH];
  logic [SUM_W-1:0] shd_sum [NUM_CH];
  logic [CNT_W-1:0] cnt_inc [NUM_CH];
  logic [SUM_W-1:0] sum_inc [NUM_CH];
  logic [SUM_W:0]   sum_ext [NUM_CH];

  // A pixel coinciding with frame_start belongs to the new frame at column 0.
  assign x_cur = frame_start ? '0 : x;

  // Saturating increments: accumulators stick at all-ones instead of wrapping.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_inc[k] = (&acc_cnt[k]) ? acc_cnt[k] : acc_cnt[k] + CNT_W'(1);
      sum_ext[k] = {1'b0, acc_sum[k]} + (SUM_W + 1)'(x_cur);
      sum_inc[k] = sum_ext[k][SUM_W] ? '1 : sum_ext[k][SUM_W-1:0];
    end
  end

  // NOTE: the accumulator and shadow arrays are small register files, not
  // RAM, so they are cleared by reset like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        acc_cnt[k] <= '0;
        acc_sum[k] <= '0;
        shd_cnt[k] <= '0;
        shd_sum[k] <= '0;
      end
    end else begin
      if (pixel_valid)
        x <= (x_cur == X_W'(H_ACTIVE - 1)) ? '0 : x_cur + X_W'(1);
      else if (frame_start)
        x <= '0;

      for (int k = 0; k < NUM_CH; k++) begin
        if (frame_start) begin
          shd_cnt[k] <= acc_cnt[k];
          shd_sum[k] <= acc_sum[k];
          acc_cnt[k] <= (pixel_valid && hit[k]) ? CNT_W'(1) : '0;
          acc_sum[k] <= '0;  // a same-cycle pixel sits at column 0
        end else if (pixel_valid && hit[k]) begin
          acc_cnt[k] <= cnt_inc[k];
          acc_sum[k] <= sum_inc[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FSM and shared divider
  // ---------------------------------------------------------------------------
  tracker_state_t   state, state_n;
  logic [CH_W-1:0]  ch, ch_n;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [SUM_W-1:0] div_dividend;
  logic [SUM_W-1:0] div_divisor;
  logic [SUM_W-1:0] div_quotient;

  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    ch_n      = ch;
    div_start = 1'b0;
    case (state)
      ST_IDLE:    ;
      ST_DIVIDE:  if (div_done || !div_busy) state_n = ST_ZONE;
      ST_ZONE: begin
        if (ch == CH_W'(NUM_CH - 1)) begin
          state_n = ST_PUBLISH;
        end else begin
          ch_n      = ch + CH_W'(1);
          state_n   = ST_DIVIDE;
          div_start = 1'b1;
        end
      end
      ST_PUBLISH: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
    // A new frame always wins: restart from channel 0 on the fresh snapshot.
    if (frame_start) begin
      state_n   = ST_DIVIDE;
      ch_n      = '0;
      div_start = 1'b1;
    end
  end

  // On frame_start the shadow registers are loaded at the same edge as the
  // divider, so channel 0's operands come straight from the accumulators.
  always_comb begin
    if (frame_start) begin
      div_dividend = acc_sum[0];
      div_divisor  = SUM_W'(acc_cnt[0]);
    end else begin
      div_dividend = shd_sum[ch_n];
      div_divisor  = SUM_W'(shd_cnt[ch_n]);
    end
  end

  seq_divider #(.SUM_W(SUM_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ch    <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Zone quantisation, pending results and published outputs
  // ---------------------------------------------------------------------------
  logic           det_c;
  logic [X_W-1:0] cx_c;
  logic [Z_W-1:0] zone_c;

  // The mean of columns 0..H_ACTIVE-1 always fits in X_W bits.
  always_comb begin
    det_c  = shd_cnt[ch] >= CNT_W'(MIN_PIXELS);
    cx_c   = det_c ? div_quotient[X_W-1:0] : '0;
    zone_c = '0;
    for (int k = 1; k < NUM_ZONES; k++)
      if (int'(cx_c) >= zone_boundary(k, H_ACTIVE, NUM_ZONES))
        zone_c = zone_c + Z_W'(1);
  end

  logic [NUM_CH-1:0]     pend_det;
  logic [NUM_CH*X_W-1:0] pend_cx;
  logic [NUM_CH*Z_W-1:0] pend_zone;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_det     <= '0;
      pend_cx      <= '0;
      pend_zone    <= '0;
      detected     <= '0;
      centroid_x   <= '0;
      zone         <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      overrun      <= frame_start && (state != ST_IDLE);
      // frame_start abandons the in-flight results: nothing is stored or
      // published in that cycle.
      if (!frame_start) begin
        if (state == ST_ZONE) begin
          pend_det[ch]                     <= det_c;
          pend_cx[int'(ch)*X_W +: X_W]     <= cx_c;
          pend_zone[int'(ch)*Z_W +: Z_W]   <= zone_c;
        end
        if (state == ST_PUBLISH) begin
          detected     <= pend_det;
          centroid_x   <= pend_cx;
          zone         <= pend_zone;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_colour_centroid_tracker.sv
// -----------------------------------------------------------------------------
// tb_colour_centroid_tracker
// Directed bench for colour_centroid_tracker with a small frame model: the
// expected result of each frame is computed from the driven pixels and queued
// at frame_start, then popped and compared when result_valid pulses.
// -----------------------------------------------------------------------------
module tb_colour_centroid_tracker;

  localparam int NUM_CH     = 2;
  localparam int H_ACTIVE   = 16;
  localparam int V_ACTIVE   = 4;
  localparam int NUM_ZONES  = 4;
  localparam int MIN_PIXELS = 2;
  localparam int X_W        = 4;
  localparam int Z_W        = 2;
  localparam int SUM_W      = 11;  // X_W + $clog2(16*4+1)
  localparam int LATENCY    = NUM_CH * (SUM_W + 1) + 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    frame_start;
  logic                    pixel_valid;
  logic [NUM_CH-1:0]       hit;
  logic                    result_valid;
  logic [NUM_CH-1:0]       detected;
  logic [NUM_CH*X_W-1:0]   centroid_x;
  logic [NUM_CH*Z_W-1:0]   zone;
  logic                    overrun;

  colour_centroid_tracker #(
    .NUM_CH     (NUM_CH),
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .NUM_ZONES  (NUM_ZONES),
    .MIN_PIXELS (MIN_PIXELS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .pixel_valid  (pixel_valid),
    .hit          (hit),
    .result_valid (result_valid),
    .detected     (detected),
    .centroid_x   (centroid_x),
    .zone         (zone),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NUM_CH-1:0]     det;
    logic [NUM_CH*X_W-1:0] cx;
    logic [NUM_CH*Z_W-1:0] zn;
    int                    due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;
  int rv_count = 0;
  int ov_count = 0;
  int n_push   = 0;

  // Frame model
  int m_cnt [NUM_CH];
  int m_sum [NUM_CH];
  int m_x;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (overrun === 1'b1) ov_count++;
    if (result_valid === 1'b1) begin
      rv_count++;
      check("result_with_queue_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("detected", 32'(detected), 32'(mon_e.det));
        check("centroid_x", 32'(centroid_x), 32'(mon_e.cx));
        check("zone", 32'(zone), 32'(mon_e.zn));
        check("latency_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NUM_CH; k++) begin
      m_cnt[k] = 0;
      m_sum[k] = 0;
    end
    m_x = 0;
  endtask

  task automatic pixel(input logic valid, input logic [NUM_CH-1:0] h);
    pixel_valid = valid;
    hit         = h;
    tick();
    if (valid) begin
      for (int k = 0; k < NUM_CH; k++)
        if (h[k]) begin
          m_cnt[k]++;
          m_sum[k] += m_x;
        end
      m_x = (m_x == H_ACTIVE - 1) ? 0 : m_x + 1;
    end
    pixel_valid = 1'b0;
    hit         = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pixel(1'b0, '0);
  endtask

  // n valid pixels; bit i of m0/m1 marks a hit on the i-th pixel of the line.
  task automatic line(input int n, input logic [31:0] m0, input logic [31:0] m1);
    for (int i = 0; i < n; i++) pixel(1'b1, {m1[i], m0[i]});
    idle(4);
  endtask

  task automatic frame(input bit push);
    exp_t e;
    int   cx;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (push) begin
      e.det = '0;
      e.cx  = '0;
      e.zn  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (m_cnt[k] >= MIN_PIXELS) begin
          cx = m_sum[k] / m_cnt[k];
          e.det[k]            = 1'b1;
          e.cx[k*X_W +: X_W]  = X_W'(cx);
          e.zn[k*Z_W +: Z_W]  = Z_W'(cx * NUM_ZONES / H_ACTIVE);
        end
      end
      e.due = cyc + LATENCY;
      sb.push_back(e);
      n_push++;
    end
    clear_model();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", sb.size(), 0);
    idle(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_result_valid"}, 32'(result_valid), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
    check({tag, "_detected"}, 32'(detected), 0);
    check({tag, "_centroid_x"}, 32'(centroid_x), 0);
    check({tag, "_zone"}, 32'(zone), 0);
  endtask

  int rv0;
  int ov0;

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    hit         = '0;
    clear_model();
    repeat (3) tick();
    reset = 1'b0;
    check_outputs_zero("reset");

    // Empty first frame: zero counts, nothing detected.
    frame(1'b1);

    // Ch0 on columns 4..7 of every line: count 16, sum 88 -> x 5, zone 1.
    for (int l = 0; l < V_ACTIVE; l++) line(16, 32'h0000_00F0, 32'h0);
    frame(1'b1);
    wait_drain();

    // Ch0 at the left edge, ch1 at the right edge.
    for (int l = 0; l < V_ACTIVE; l++) line(16, 32'h0000_0001, 32'h0000_8000);
    frame(1'b1);
    wait_drain();

    // Single hit at column 9: below MIN_PIXELS, reported as not detected.
    line(16, 32'h0000_0200, 32'h0);
    frame(1'b1);
    wait_drain();

    // Overrun: second frame_start 5 cycles after the first.
    rv0 = rv_count;
    ov0 = ov_count;
    line(16, 32'h0000_1000, 32'h0);
    line(16, 32'h0000_1000, 32'h0);
    frame(1'b0);
    pixel(1'b1, 2'b00);
    pixel(1'b1, 2'b00);
    pixel(1'b1, 2'b10);
    pixel(1'b1, 2'b10);
    frame(1'b1);
    wait_drain();
    check("overrun_pulses", ov_count - ov0, 1);
    check("overrun_publishes", rv_count - rv0, 1);

    // Reset during DIVIDE.
    line(16, 32'h0000_0100, 32'h0);
    line(16, 32'h0000_0100, 32'h0);
    frame(1'b0);
    idle(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    check_outputs_zero("mid_divide_reset");
    rv0 = rv_count;
    idle(40);
    check("no_publish_after_reset", rv_count - rv0, 0);
    line(16, 32'h0000_0028, 32'h0);
    frame(1'b1);
    wait_drain();

    // Column wrap: 20 valid pixels; pixels 17/18 land on columns 0/1 again.
    line(20, 32'h0001_0001, 32'h0002_0002);
    frame(1'b1);
    wait_drain();

    check("total_publishes", rv_count, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
